modexp_sequencer: RTL and testbench
===================================

Name: modexp_sequencer

Overview:
- Parametrised control sequencer for Montgomery-multiplier based modular exponentiation (right-to-left square-and-multiply).
- Drives the MMM datapath load, lock and select strobes through three phases: PRE (domain conversion), ITER (one per exponent bit) and POST (conversion out).
- Supports a generic exponent width, a runtime bit count, a configurable MMM latency and an optional done-driven handshake mode.
- Has a start/busy/eoc handshake instead of free-running operation.

Parameters:
- EXP_WIDTH, 1026, exponent register width.
- LEN_WIDTH, 11, width of exp_len; must satisfy 2**LEN_WIDTH > EXP_WIDTH.
- MMM_CYCLES, 11, cycles from ld_a to ld_r in fixed-latency mode; minimum 2.
- USE_DONE, 0, 0 = fixed latency; 1 = the ld_r timing follows mmm_done.

Ports:
- clk  in  1  system clock.
- rstb  in  1  asynchronous active-low reset.
- en  in  1  clock enable; 0 freezes all state and outputs.
- start  in  1  request a new exponentiation; sampled in IDLE or DONE only.
- exp_e  in  EXP_WIDTH  exponent; captured on start acceptance.
- exp_len  in  LEN_WIDTH  number of exponent bits to process; captured on start acceptance.
- mmm_done  in  1  MMM result valid (USE_DONE=1 only).
- rst_mmm  out  1  active-low MMM reset.
- ld_a  out  1  load MMM operands / start operation.
- ld_r  out  1  capture MMM result.
- lock1  out  1  result-register update enable.
- lock2  out  1  square-register update enable.
- sel1  out  2  operand mux: 00 PRE, 01 ITER, 10 POST.
- sel2  out  1  operand mux: 0 PRE, 1 otherwise.
- busy  out  1  run in progress.
- eoc  out  1  end of computation.

Behaviour:
- All outputs are registered (Moore).
- Reset (rstb=0, asynchronous): state IDLE, exponent register and counters cleared. Outputs: rst_mmm=0, ld_a=0, ld_r=0, lock1=0, lock2=0, sel1=00, sel2=0, busy=0, eoc=0. Reset mid-run aborts immediately with no further strobes.
- en=0: state, counters, exponent register and outputs are held; start and mmm_done are ignored.
- States: IDLE, PRE_LD, PRE_RUN, IT_LD, IT_RUN, POST_LD, POST_RUN, DONE.
- Start acceptance (IDLE or DONE, start=1): capture exp_e; capture N = min(exp_len, EXP_WIDTH); go to PRE_LD. start is ignored in all other states.
- Each operation is an *_LD cycle followed by *_RUN cycles:
  - *_LD cycle: ld_a=1, ld_r=0.
  - USE_DONE=0: the op counter asserts ld_r exactly MMM_CYCLES cycles after the ld_a cycle. Op period P = MMM_CYCLES+1. The next ld_a follows ld_r in the very next cycle.
  - USE_DONE=1: ld_r is asserted in the cycle after mmm_done is sampled high in *_RUN. mmm_done is ignored in *_LD, in the ld_r cycle and outside runs. There is no timeout.
- Phase outputs (rst_mmm=1, busy=1 throughout):
  - PRE: sel1=00, sel2=0, lock1=1, lock2=1.
  - ITER: sel1=01, sel2=1, lock1 = current exponent LSB (held constant for the whole iteration), lock2=1.
  - POST: sel1=10, sel2=1, lock1=1, lock2=0.
- Transitions:
  - At PRE ld_r: go to IT_LD if N>0, else go to POST_LD (N=0 skips ITER; result = converted 1).
  - At each ITER ld_r: shift the exponent register right by 1 and decrement the remaining count. On reaching 0, go to POST_LD; otherwise go to IT_LD.
  - At POST ld_r: go to DONE.
- DONE: eoc=1, busy=0, rst_mmm=1; sel/lock hold POST values; ld_a=ld_r=0. State held until a new start. On start, eoc deasserts in the cycle PRE_LD outputs appear.
- Timing (USE_DONE=0): first ld_a is high in the first cycle after the accepting edge (cycle 1). Op i (0..N+1) has ld_a at cycle 1+i·P and ld_r at cycle (i+1)·P. eoc rises at cycle (N+2)·P+1.
- Exponent bits above N are never examined. exp_e and exp_len changes during a run have no effect.

Test Plan:
- MMM_CYCLES=11, N=8, exp_e=0xA5, start pulse → ld_a at cycles 1,13,…,109; lock1 per ITER = 1,0,1,0,0,1,0,1; sel1 sequence 00, 01×8, 10; eoc rises at cycle 121; busy falls at cycle 121.
- exp_len=0 → exactly two ops (PRE, POST), no sel1=01 cycles, eoc at cycle 25.
- exp_len=2000 with EXP_WIDTH=1026 → exactly 1026 ITER ops (clamped); eoc at cycle 1028·12+1.
- USE_DONE=1, mmm_done pulsed 5, 20 and 3 cycles after each ld_a, N=1 → ld_r one cycle after each mmm_done; spurious mmm_done in IDLE produces no strobe.
- en held low 7 cycles mid-ITER → every output frozen; eoc delayed exactly 7 cycles; start asserted mid-run ignored.
- rstb low mid-ITER → all outputs to reset values asynchronously; subsequent start yields a full clean run matching scenario 1.

Source files
------------

// File: rtl/modexp_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : modexp_sequencer
// Purpose  : Control sequencer for Montgomery-multiplier based right-to-left
//            square-and-multiply modular exponentiation. Steps the MMM
//            datapath through PRE, one ITER per exponent bit, and POST
//            operations, with a start/busy/eoc handshake.
// Revision : 1.0 - initial release
// ============================================================================
module modexp_sequencer #(
  parameter int EXP_WIDTH  = 1026,
  parameter int LEN_WIDTH  = 11,
  parameter int MMM_CYCLES = 11,
  parameter int USE_DONE   = 0
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 en,
  input  logic                 start,
  input  logic [EXP_WIDTH-1:0] exp_e,
  input  logic [LEN_WIDTH-1:0] exp_len,
  input  logic                 mmm_done,
  output logic                 rst_mmm,
  output logic                 ld_a,
  output logic                 ld_r,
  output logic                 lock1,
  output logic                 lock2,
  output logic [1:0]           sel1,
  output logic                 sel2,
  output logic                 busy,
  output logic                 eoc
);

  localparam int                  CNT_W     = $clog2(MMM_CYCLES + 1);
  localparam logic [CNT_W-1:0]    C_LDR_AT  = CNT_W'(MMM_CYCLES - 1);
  localparam logic [LEN_WIDTH-1:0] C_EXP_MAX = LEN_WIDTH'(EXP_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PRE_LD   = 3'd1,
    S_PRE_RUN  = 3'd2,
    S_IT_LD    = 3'd3,
    S_IT_RUN   = 3'd4,
    S_POST_LD  = 3'd5,
    S_POST_RUN = 3'd6,
    S_DONE     = 3'd7
  } state_t;

  state_t                 state_q, state_d;
  logic [EXP_WIDTH-1:0]   exp_q, exp_d;
  logic [LEN_WIDTH-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   rst_mmm_q, rst_mmm_d;
  logic                   ld_a_q, ld_a_d;
  logic                   ld_r_q, ld_r_d;
  logic                   lock1_q, lock1_d;
  logic                   lock2_q, lock2_d;
  logic [1:0]             sel1_q, sel1_d;
  logic                   sel2_q, sel2_d;
  logic                   busy_q, busy_d;
  logic                   eoc_q, eoc_d;

  // Next-state: op sequencing, exponent shifting and remaining-bit count.
  // ld_r_q marks the capture cycle of the current op, so it doubles as the
  // "op finished" flag for the phase transition.
  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    ld_r_d  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          exp_d   = exp_e;
          rem_d   = (exp_len > C_EXP_MAX) ? C_EXP_MAX : exp_len;
          state_d = S_PRE_LD;
        end
      end
      S_PRE_LD: begin
        state_d = S_PRE_RUN;
        cnt_d   = CNT_W'(1);
      end
      S_IT_LD: begin
        state_d = S_IT_RUN;
        cnt_d   = CNT_W'(1);
      end
      S_POST_LD: begin
        state_d = S_POST_RUN;
        cnt_d   = CNT_W'(1);
      end
      default: begin
        if (ld_r_q) begin
          case (state_q)
            S_PRE_RUN:  state_d = (rem_q != '0) ? S_IT_LD : S_POST_LD;
            S_IT_RUN: begin
              exp_d   = exp_q >> 1;
              rem_d   = rem_q - LEN_WIDTH'(1);
              state_d = (rem_q == LEN_WIDTH'(1)) ? S_POST_LD : S_IT_LD;
            end
            default:    state_d = S_DONE;
          endcase
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (USE_DONE != 0) begin
            ld_r_d = mmm_done;
          end else begin
            ld_r_d = (cnt_q == C_LDR_AT);
          end
        end
      end
    endcase
  end

  // Output decode from the next state so every strobe leaves a flop.
  always_comb begin
    rst_mmm_d = 1'b1;
    ld_a_d    = 1'b0;
    lock1_d   = 1'b0;
    lock2_d   = 1'b0;
    sel1_d    = 2'b00;
    sel2_d    = 1'b0;
    busy_d    = 1'b1;
    eoc_d     = 1'b0;
    case (state_d)
      S_PRE_LD, S_PRE_RUN: begin
        ld_a_d  = (state_d == S_PRE_LD);
        lock1_d = 1'b1;
        lock2_d = 1'b1;
      end
      S_IT_LD, S_IT_RUN: begin
        ld_a_d  = (state_d == S_IT_LD);
        lock1_d = exp_d[0];
        lock2_d = 1'b1;
        sel1_d  = 2'b01;
        sel2_d  = 1'b1;
      end
      S_POST_LD, S_POST_RUN: begin
        ld_a_d  = (state_d == S_POST_LD);
        lock1_d = 1'b1;
        sel1_d  = 2'b10;
        sel2_d  = 1'b1;
      end
      S_DONE: begin
        lock1_d = 1'b1;
        sel1_d  = 2'b10;
        sel2_d  = 1'b1;
        busy_d  = 1'b0;
        eoc_d   = 1'b1;
      end
      default: begin
        rst_mmm_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  // State and output registers; en low freezes everything.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q   <= S_IDLE;
      exp_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      rst_mmm_q <= 1'b0;
      ld_a_q    <= 1'b0;
      ld_r_q    <= 1'b0;
      lock1_q   <= 1'b0;
      lock2_q   <= 1'b0;
      sel1_q    <= 2'b00;
      sel2_q    <= 1'b0;
      busy_q    <= 1'b0;
      eoc_q     <= 1'b0;
    end else if (en) begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      rst_mmm_q <= rst_mmm_d;
      ld_a_q    <= ld_a_d;
      ld_r_q    <= ld_r_d;
      lock1_q   <= lock1_d;
      lock2_q   <= lock2_d;
      sel1_q    <= sel1_d;
      sel2_q    <= sel2_d;
      busy_q    <= busy_d;
      eoc_q     <= eoc_d;
    end
  end

  assign rst_mmm = rst_mmm_q;
  assign ld_a    = ld_a_q;
  assign ld_r    = ld_r_q;
  assign lock1   = lock1_q;
  assign lock2   = lock2_q;
  assign sel1    = sel1_q;
  assign sel2    = sel2_q;
  assign busy    = busy_q;
  assign eoc     = eoc_q;

endmodule
`default_nettype wire

// File: tb/tb_modexp_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_modexp_sequencer
// Purpose  : Directed self-checking bench for modexp_sequencer (fixed-latency
//            instance plus a done-handshake instance).
// Revision : 1.0 - initial release
// ============================================================================
module tb_modexp_sequencer;

  localparam int P = 12;

  logic          clk = 1'b0;
  logic          rstb = 1'b0;
  logic          en = 1'b1;
  logic          start = 1'b0;
  logic          start1 = 1'b0;
  logic          mmm_done = 1'b0;
  logic [1025:0] exp_e = '0;
  logic [10:0]   exp_len = '0;

  logic       rst_mmm0, ld_a0, ld_r0, lock1_0, lock2_0, sel2_0, busy0, eoc0;
  logic [1:0] sel1_0;
  logic       rst_mmm1, ld_a1, ld_r1, lock1_1, lock2_1, sel2_1, busy1, eoc1;
  logic [1:0] sel1_1;

  int n_assert = 0;
  int n_fail   = 0;

  modexp_sequencer #(.EXP_WIDTH(1026), .LEN_WIDTH(11), .MMM_CYCLES(11), .USE_DONE(0)) dut0 (
    .clk(clk), .rstb(rstb), .en(en), .start(start), .exp_e(exp_e), .exp_len(exp_len),
    .mmm_done(mmm_done), .rst_mmm(rst_mmm0), .ld_a(ld_a0), .ld_r(ld_r0), .lock1(lock1_0),
    .lock2(lock2_0), .sel1(sel1_0), .sel2(sel2_0), .busy(busy0), .eoc(eoc0)
  );

  modexp_sequencer #(.EXP_WIDTH(1026), .LEN_WIDTH(11), .MMM_CYCLES(11), .USE_DONE(1)) dut1 (
    .clk(clk), .rstb(rstb), .en(en), .start(start1), .exp_e(exp_e), .exp_len(exp_len),
    .mmm_done(mmm_done), .rst_mmm(rst_mmm1), .ld_a(ld_a1), .ld_r(ld_r1), .lock1(lock1_1),
    .lock2(lock2_1), .sel1(sel1_1), .sel2(sel2_1), .busy(busy1), .eoc(eoc1)
  );

  always #5 clk = ~clk;

  // {rst_mmm, ld_a, ld_r, lock1, lock2, sel1[1:0], sel2, busy, eoc}
  function automatic logic [9:0] obs0();
    return {rst_mmm0, ld_a0, ld_r0, lock1_0, lock2_0, sel1_0, sel2_0, busy0, eoc0};
  endfunction

  function automatic logic [9:0] obs1();
    return {rst_mmm1, ld_a1, ld_r1, lock1_1, lock2_1, sel1_1, sel2_1, busy1, eoc1};
  endfunction

  // Expected outputs at cycle ce after the accepting edge, fixed latency.
  function automatic logic [9:0] expv(input int n, input logic [1025:0] e, input int ce);
    int i;
    logic [9:0] v;
    if (ce > (n + 2) * P)
      return {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 1'b1};
    i = (ce - 1) / P;
    v[9] = 1'b1;
    v[8] = ((ce - 1) % P == 0);
    v[7] = (ce % P == 0);
    v[1] = 1'b1;
    v[0] = 1'b0;
    if (i == 0)      {v[6], v[5], v[4:3], v[2]} = {1'b1, 1'b1, 2'b00, 1'b0};
    else if (i <= n) {v[6], v[5], v[4:3], v[2]} = {e[i-1], 1'b1, 2'b01, 1'b1};
    else             {v[6], v[5], v[4:3], v[2]} = {1'b1, 1'b0, 2'b10, 1'b1};
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_assert++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, req);
    end
  endtask

  // One full run on dut0 with optional en-low window; checks every cycle.
  task automatic run(input int n, input logic [1025:0] e, input logic [10:0] len_in,
                     input int frz_at, input int frz_len, input string tag,
                     output int eoc_cyc, output int lda_cnt, output int it_cnt,
                     output logic [31:0] lk);
    int total, ce, bad, fb, itk;
    logic frozen;
    logic [9:0] ob, ex, fbo, fbe;
    exp_e = e; exp_len = len_in; start = 1'b1;
    step();
    start = 1'b0;
    total = (n + 2) * P + 1 + frz_len;
    bad = 0; fb = 0; fbo = '0; fbe = '0; itk = 0;
    eoc_cyc = -1; lda_cnt = 0; it_cnt = 0; lk = '0;
    for (int c = 1; c <= total + 3; c++) begin
      if (c <= frz_at) ce = c;
      else if (c <= frz_at + frz_len) ce = frz_at;
      else ce = c - frz_len;
      ex = expv(n, e, ce);
      ob = obs0();
      if (ob !== ex) begin
        if (bad == 0) begin fb = c; fbo = ob; fbe = ex; end
        bad++;
      end
      if (ob[8]) lda_cnt++;
      if (ob[4:3] == 2'b01) begin
        it_cnt++;
        if (ob[8]) begin
          if (itk < 32) lk[itk] = ob[6];
          itk++;
        end
      end
      if (ob[0] && eoc_cyc < 0) eoc_cyc = c;
      frozen   = (frz_len > 0) && (c >= frz_at) && (c < frz_at + frz_len);
      en       = !frozen;
      mmm_done = frozen;
      start    = frozen || ((frz_len > 0) && (c == frz_at + frz_len + 1));
      if (c == 2) begin exp_e = ~e; exp_len = 11'd1; end
      step();
    end
    start = 1'b0; en = 1'b1; mmm_done = 1'b0;
    n_assert++;
    assert (bad === 0) else begin
      n_fail++;
      $error("FAIL %s_trace: %0d bad cycles, first at cycle %0d observed %b expected %b",
             tag, bad, fb, fbo, fbe);
    end
  endtask

  initial begin
    int ec, la, ic, na, nr, e1;
    int a[3], r[3];
    logic [31:0] lk;
    logic [9:0]  acc;
    logic [2:0]  it8;
    logic [1025:0] big;

    // Reset state
    rstb = 1'b0;
    repeat (3) step();
    chk("reset_dut0", 32'(obs0()), 32'd0);
    chk("reset_dut1", 32'(obs1()), 32'd0);
    rstb = 1'b1;
    step();

    // Spurious mmm_done while dut1 idle: no strobes, no run
    acc = '0;
    for (int k = 0; k < 4; k++) begin
      mmm_done = 1'b1;
      step();
      acc |= obs1();
    end
    mmm_done = 1'b0;
    chk("idle_mmm_done", 32'(acc), 32'd0);

    // Done-handshake run, N=1; extra mmm_done in ld_r (7) and LD (8) cycles
    exp_e = 1026'h1; exp_len = 11'd1; start1 = 1'b1;
    step();
    start1 = 1'b0;
    na = 0; nr = 0; e1 = -1; it8 = '0;
    for (int c = 1; c <= 40; c++) begin
      if (ld_a1) begin if (na < 3) a[na] = c; na++; end
      if (ld_r1) begin if (nr < 3) r[nr] = c; nr++; end
      if (eoc1 && e1 < 0) e1 = c;
      if (c == 8) it8 = {sel1_1, lock1_1};
      mmm_done = (c == 6) || (c == 7) || (c == 8) || (c == 28) || (c == 33);
      step();
    end
    mmm_done = 1'b0;
    chk("hs_lda_count", na, 3);
    chk("hs_ldr_count", nr, 3);
    chk("hs_lda0", a[0], 1);
    chk("hs_lda1", a[1], 8);
    chk("hs_lda2", a[2], 30);
    chk("hs_ldr0", r[0], 7);
    chk("hs_ldr1", r[1], 29);
    chk("hs_ldr2", r[2], 34);
    chk("hs_eoc", e1, 35);
    chk("hs_iter_sel_lock", 32'(it8), 32'b011);

    // Scenario 1: N=8, exp 0xA5
    run(8, 1026'hA5, 11'd8, 0, 0, "s1", ec, la, ic, lk);
    chk("s1_eoc", ec, 121);
    chk("s1_lda_count", la, 10);
    chk("s1_iter_cycles", ic, 96);
    chk("s1_lock1_seq", 32'(lk[7:0]), 32'hA5);

    // Scenario 2: exp_len=0, started from DONE
    run(0, 1026'h3, 11'd0, 0, 0, "s2", ec, la, ic, lk);
    chk("s2_eoc", ec, 25);
    chk("s2_lda_count", la, 2);
    chk("s2_iter_cycles", ic, 0);

    // Scenario 3: exp_len=2000 clamps to 1026
    for (int k = 0; k < 1026; k++) big[k] = 1'($urandom_range(0, 1));
    run(1026, big, 11'd2000, 0, 0, "s3", ec, la, ic, lk);
    chk("s3_eoc", ec, 12337);
    chk("s3_lda_count", la, 1028);
    chk("s3_iter_cycles", ic, 12312);

    // Scenario 4: en low 7 cycles mid-ITER, start during and after freeze
    run(3, 1026'h5, 11'd3, 30, 7, "s4", ec, la, ic, lk);
    chk("s4_eoc", ec, 68);
    chk("s4_lda_count", la, 5);
    chk("s4_lock1_seq", 32'(lk[2:0]), 32'b101);

    // Scenario 5: asynchronous reset mid-ITER, then a clean run
    exp_e = 1026'hA5; exp_len = 11'd8; start = 1'b1;
    step();
    start = 1'b0;
    repeat (39) step();
    chk("s5_mid_run", 32'({busy0, sel1_0}), 32'b101);
    #2 rstb = 1'b0;
    #1;
    chk("s5_async_reset", 32'(obs0()), 32'd0);
    acc = '0;
    repeat (3) begin
      step();
      acc |= obs0();
    end
    chk("s5_reset_hold", 32'(acc), 32'd0);
    rstb = 1'b1;
    step();
    run(8, 1026'hA5, 11'd8, 0, 0, "s5_rerun", ec, la, ic, lk);
    chk("s5_rerun_eoc", ec, 121);
    chk("s5_rerun_lock1_seq", 32'(lk[7:0]), 32'hA5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
